// File: rtl/instr_decoder_seq.sv
// ============================================================================
// instr_decoder_seq : byte-stream opcode decoder with operand collection
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_decoder_seq #(
  parameter int DW   = 8,
  parameter int OPB  = 1,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         ctrl,
  output logic [DW*OPB-1:0]   operand,
  output logic                illegal,
  output logic [CNTW-1:0]     instr_count
);

  localparam int            CW     = $clog2(OPB + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OPB - 1);

  typedef enum logic [1:0] {
    S_OPC  = 2'd0,
    S_OPND = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         ctrl_q, ctrl_d;
  logic [DW*OPB-1:0]   operand_q, operand_d;
  logic                illegal_q, illegal_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                w_known;
  logic                w_has_opnd;
  logic [4:0]          w_idx;
  logic                w_hi_zero;
  logic                w_legal;
  logic                w_accept;

  // Opcodes wider than a byte are legal only with all upper bits clear.
  generate
    if (DW > 8) begin : g_hi_check
      assign w_hi_zero = ~|in_data[DW-1:8];
    end else begin : g_no_hi
      assign w_hi_zero = 1'b1;
    end
  endgenerate

  always_comb begin
    w_known    = 1'b1;
    w_has_opnd = 1'b0;
    w_idx      = 5'd0;
    case (in_data[7:0])
      8'h00: w_idx = 5'd0;
      8'h0B: w_idx = 5'd1;
      8'h07: w_idx = 5'd2;
      8'h50: w_idx = 5'd3;
      8'h52: w_idx = 5'd4;
      8'h54: w_idx = 5'd5;
      8'h55: w_idx = 5'd6;
      8'h51: w_idx = 5'd7;
      8'h15: w_idx = 5'd8;
      8'h10: w_idx = 5'd9;
      8'h14: w_idx = 5'd10;
      8'h16: w_idx = 5'd11;
      8'hD6: begin w_idx = 5'd12; w_has_opnd = 1'b1; end
      8'hD0: begin w_idx = 5'd13; w_has_opnd = 1'b1; end
      8'hD4: begin w_idx = 5'd14; w_has_opnd = 1'b1; end
      8'hD2: begin w_idx = 5'd15; w_has_opnd = 1'b1; end
      8'h83: w_idx = 5'd16;
      8'h84: w_idx = 5'd17;
      8'h88: w_idx = 5'd18;
      8'h8A: w_idx = 5'd19;
      8'h8B: w_idx = 5'd20;
      8'h8C: w_idx = 5'd21;
      8'h8D: w_idx = 5'd22;
      8'h98: w_idx = 5'd23;
      8'h9A: w_idx = 5'd24;
      8'hA0: w_idx = 5'd25;
      8'hA1: w_idx = 5'd26;
      8'hA2: w_idx = 5'd27;
      8'hA8: w_idx = 5'd28;
      8'hB0: w_idx = 5'd29;
      8'hB9: w_idx = 5'd30;
      8'hBD: w_idx = 5'd31;
      default: w_known = 1'b0;
    endcase
  end

  assign w_legal  = w_known & w_hi_zero;
  assign in_ready = rst_n & ~flush & (state_q != S_HOLD);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    operand_d = operand_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    cnt_d     = cnt_q;
    if (flush) begin
      state_d   = S_OPC;
      ctrl_d    = 32'd0;
      illegal_d = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_OPC: begin
          if (w_accept) begin
            if (!w_legal) begin
              ctrl_d    = 32'd1;
              illegal_d = 1'b1;
              operand_d = '0;
              state_d   = S_HOLD;
            end else begin
              ctrl_d    = 32'd1 << w_idx;
              illegal_d = 1'b0;
              if (w_has_opnd) begin
                cnt_d   = '0;
                state_d = S_OPND;
              end else begin
                operand_d = '0;
                state_d   = S_HOLD;
              end
            end
          end
        end
        S_OPND: begin
          if (w_accept) begin
            operand_d[int'(cnt_q)*DW +: DW] = in_data;
            if (cnt_q == C_LAST) begin
              state_d = S_HOLD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            count_d = count_q + CNTW'(1);
            state_d = S_OPC;
          end
        end
        default: state_d = S_OPC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_OPC;
      ctrl_q    <= 32'd0;
      operand_q <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      operand_q <= operand_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid   = (state_q == S_HOLD);
  assign ctrl        = ctrl_q;
  assign operand     = operand_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_decoder_seq.sv
// ============================================================================
// tb_instr_decoder_seq : directed + randomized bench with a transaction model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_decoder_seq;

  localparam int DW   = 8;
  localparam int OPB  = 2;
  localparam int CNTW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       ctrl;
  logic [DW*OPB-1:0] operand;
  logic              illegal;
  logic [CNTW-1:0]   instr_count;

  instr_decoder_seq #(.DW(DW), .OPB(OPB), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ctrl        (ctrl),
    .operand     (operand),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode listed at position i selects ctrl bit i.
  logic [7:0] tab [32] = '{
    8'h00, 8'h0B, 8'h07, 8'h50, 8'h52, 8'h54, 8'h55, 8'h51,
    8'h15, 8'h10, 8'h14, 8'h16, 8'hD6, 8'hD0, 8'hD4, 8'hD2,
    8'h83, 8'h84, 8'h88, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h98,
    8'h9A, 8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hB0, 8'hB9, 8'hBD
  };

  function automatic int find_op(input logic [7:0] b);
    for (int i = 0; i < 32; i++) if (tab[i] == b) return i;
    return -1;
  endfunction

  function automatic bit takes_operand(input logic [7:0] b);
    return (b == 8'hD6) || (b == 8'hD0) || (b == 8'hD4) || (b == 8'hD2);
  endfunction

  // Transaction-level model: a pending instruction, words still owed, and
  // whether a finished instruction awaits the consumer.
  bit                m_live = 0;
  bit                m_rst = 0;
  bit                m_out = 0;
  int                m_left = 0;
  int                m_pos = 0;
  int                m_count = 0;
  int                m_idx;
  logic [31:0]       m_ctrl = '0;
  logic [DW*OPB-1:0] m_op = '0;
  logic              m_ill = 1'b0;

  always @(posedge clk) begin
    m_live = 1;
    m_rst  = 0;
    if (!rst_n) begin
      m_out = 0; m_left = 0; m_pos = 0; m_count = 0;
      m_ctrl = '0; m_op = '0; m_ill = 1'b0; m_rst = 1;
    end else if (flush) begin
      m_out = 0; m_left = 0; m_pos = 0; m_ctrl = '0; m_ill = 1'b0;
    end else if (m_out) begin
      if (out_ready) begin
        m_out   = 0;
        m_count = (m_count + 1) % (1 << CNTW);
      end
    end else if (in_valid) begin
      if (m_left > 0) begin
        m_op[m_pos*DW +: DW] = in_data;
        m_pos++;
        m_left--;
        if (m_left == 0) m_out = 1;
      end else begin
        m_idx = find_op(in_data);
        if (m_idx < 0) begin
          m_ctrl = 32'd1; m_ill = 1'b1; m_op = '0; m_out = 1;
        end else begin
          m_ctrl = 32'd1 << m_idx;
          m_ill  = 1'b0;
          if (takes_operand(in_data)) begin
            m_left = OPB; m_pos = 0;
          end else begin
            m_op = '0; m_out = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", in_ready, rst_n && !flush && !m_out);
      chk("out_valid", out_valid, m_out);
      chk("instr_count", instr_count, m_count[CNTW-1:0]);
      if (m_out || m_rst) begin
        chk("ctrl", ctrl, m_ctrl);
        chk("operand", operand, m_op);
        chk("illegal", illegal, m_ill);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] c, input logic [15:0] op,
                            input logic il, output int waits);
    waits = 0;
    @(negedge clk);
    while (!out_valid && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_ctrl"}, ctrl, c);
    chk({name, "_operand"}, operand, op);
    chk({name, "_illegal"}, illegal, il);
  endtask

  int w;
  int r;

  initial begin
    // Reset, then release.
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_out_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_count", instr_count, 0);
    tick();

    // Single no-operand opcode with immediate handoff.
    send(8'h50);
    expect_out("add_s", 32'h0000_0008, 16'h0, 1'b0, w);
    chk("add_s_latency", w, 0);
    tick();
    @(negedge clk);
    chk("add_s_drop", out_valid, 0);
    chk("add_s_count", instr_count, 1);
    tick();

    // Operand opcode, back to back and with input gaps.
    send(8'hD4); send(8'h34); send(8'h12);
    expect_out("jmp", 32'h0000_4000, 16'h1234, 1'b0, w);
    chk("jmp_latency", w, 0);
    tick();
    send(8'hD4); repeat (3) tick();
    send(8'h34); repeat (3) tick();
    send(8'h12);
    expect_out("jmp_gap", 32'h0000_4000, 16'h1234, 1'b0, w);
    chk("jmp_gap_latency", w, 0);
    tick();

    // Backpressure: held output, next opcode waits for the handoff.
    out_ready = 1'b0;
    send(8'h07);
    in_valid = 1'b1;
    in_data  = 8'hBD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ctrl", ctrl, 32'h4);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    send(8'hBD);
    expect_out("mov_inr_rr", 32'h8000_0000, 16'h0, 1'b0, w);
    tick();

    // Illegal opcode is counted like any other.
    send(8'hFF);
    expect_out("illegal", 32'h1, 16'h0, 1'b1, w);
    tick();
    @(negedge clk);
    chk("illegal_count", instr_count, 6);
    tick();

    // Flush before the operand arrives.
    send(8'hD0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_valid", out_valid, 0);
      chk("flush_count", instr_count, 6);
      tick();
    end
    send(8'h55);
    expect_out("div_s", 32'h0000_0040, 16'h0, 1'b0, w);
    tick();

    // Reset in the middle of operand collection.
    send(8'hD6); send(8'hAA);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_count", instr_count, 0);
      tick();
    end
    send(8'hD2); send(8'h01); send(8'h02);
    expect_out("jge", 32'h0000_8000, 16'h0201, 1'b0, w);
    tick();

    // Counter wrap at 16 handoffs.
    for (int i = 0; i < 14; i++) begin
      send(8'h0B);
      expect_out("outb", 32'h2, 16'h0, 1'b0, w);
      tick();
    end
    @(negedge clk);
    chk("count_15", instr_count, 15);
    tick();
    send(8'h0B);
    expect_out("outb_last", 32'h2, 16'h0, 1'b0, w);
    tick();
    @(negedge clk);
    chk("count_wrap", instr_count, 0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 5)      in_data = tab[$urandom_range(0, 31)];
      else if (r < 7) in_data = tab[12 + $urandom_range(0, 3)];
      else            in_data = 8'($urandom_range(0, 255));
      tick();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
